// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter sharing one external 16-entry sprite palette among NUM_REQ
// pixel requesters, with a two-stage lookup/response pipeline and writer backpressure.
module palette_lookup_arbiter #(
  parameter int          NUM_REQ         = 4,
  parameter int          ID_W            = 2,
  parameter logic [3:0]  TRANSPARENT_IDX = 4'h0
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_index,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [3:0]             pal_index,
  input  logic [3:0]             pal_red,
  input  logic [3:0]             pal_green,
  input  logic [3:0]             pal_blue,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [3:0]             rsp_red,
  output logic [3:0]             rsp_green,
  output logic [3:0]             rsp_blue,
  output logic                   rsp_transparent
);

  function automatic logic is_transparent(input logic [3:0] idx);
    return (idx == TRANSPARENT_IDX);
  endfunction

  // Candidate ID k steps after base, wrapping modulo NUM_REQ.
  function automatic logic [ID_W-1:0] rr_step(input logic [ID_W-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return ID_W'(sum);
  endfunction

  logic                 r_s1_valid;
  logic [ID_W-1:0]      r_s1_id;
  logic [3:0]           r_s1_index;
  logic [ID_W-1:0]      r_last_grant;
  logic                 r_rsp_valid;
  logic [ID_W-1:0]      r_rsp_id;
  logic [3:0]           r_rsp_red;
  logic [3:0]           r_rsp_green;
  logic [3:0]           r_rsp_blue;
  logic                 r_rsp_transparent;

  logic                 w_advance1;
  logic                 w_advance2;
  logic                 w_grant_found;
  logic [ID_W-1:0]      w_grant_id;
  logic [ID_W-1:0]      w_cand_id;
  logic [3:0]           w_grant_index;
  logic [NUM_REQ-1:0]   w_req_ready;
  logic                 w_transfer;

  assign w_advance2 = !r_rsp_valid || rsp_ready;
  assign w_advance1 = !r_s1_valid || w_advance2;

  // Round-robin search starting one past the most recent grant.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = {ID_W{1'b0}};
    w_cand_id     = {ID_W{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand_id = rr_step(r_last_grant, k);
      if (!w_grant_found && req_valid[w_cand_id]) begin
        w_grant_found = 1'b1;
        w_grant_id    = w_cand_id;
      end else begin
        w_grant_found = w_grant_found;
      end
    end
  end

  // One-hot grant, suppressed while stalled or in reset.
  always_comb begin
    w_req_ready = {NUM_REQ{1'b0}};
    if (!Reset && w_advance1 && w_grant_found) begin
      w_req_ready[w_grant_id] = 1'b1;
    end else begin
      w_req_ready = {NUM_REQ{1'b0}};
    end
  end

  assign w_transfer    = |(req_valid & w_req_ready);
  assign w_grant_index = req_index[int'(w_grant_id)*4 +: 4];

  // Lookup stage and round-robin pointer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_id      <= {ID_W{1'b0}};
      r_s1_index   <= 4'h0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
    end else if (w_advance1) begin
      if (w_transfer) begin
        r_s1_valid   <= 1'b1;
        r_s1_id      <= w_grant_id;
        r_s1_index   <= w_grant_index;
        r_last_grant <= w_grant_id;
      end else begin
        r_s1_valid   <= 1'b0;
      end
    end else begin
      r_s1_valid <= r_s1_valid;
    end
  end

  // Response stage captures the palette colour for the pixel in S1.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rsp_valid       <= 1'b0;
      r_rsp_id          <= {ID_W{1'b0}};
      r_rsp_red         <= 4'h0;
      r_rsp_green       <= 4'h0;
      r_rsp_blue        <= 4'h0;
      r_rsp_transparent <= 1'b0;
    end else if (w_advance2) begin
      r_rsp_valid       <= r_s1_valid;
      r_rsp_id          <= r_s1_id;
      r_rsp_red         <= pal_red;
      r_rsp_green       <= pal_green;
      r_rsp_blue        <= pal_blue;
      r_rsp_transparent <= is_transparent(r_s1_index);
    end else begin
      r_rsp_valid <= r_rsp_valid;
    end
  end

  assign req_ready       = w_req_ready;
  assign pal_index       = r_s1_index;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_id          = r_rsp_id;
  assign rsp_red         = r_rsp_red;
  assign rsp_green       = r_rsp_green;
  assign rsp_blue        = r_rsp_blue;
  assign rsp_transparent = r_rsp_transparent;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Scoreboard bench for palette_lookup_arbiter: a reference model predicts grants and
// pipeline occupancy; expected responses are queued at grant time and popped on drain.
module tb_palette_lookup_arbiter;
  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  req_valid;
  logic [15:0] req_index;
  logic [3:0]  req_ready;
  logic [3:0]  pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_red, rsp_green, rsp_blue;
  logic        rsp_transparent;

  int total = 0;
  int bad   = 0;

  logic [14:0] sb_q[$];
  logic        m_s1_valid, m_rsp_valid;
  int          m_last;
  logic [3:0]  obs_ready;
  logic [14:0] obs_rsp, held_rsp;

  always #5 Clk = ~Clk;

  palette_lookup_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
    .pal_index(pal_index), .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_red(rsp_red), .rsp_green(rsp_green), .rsp_blue(rsp_blue),
    .rsp_transparent(rsp_transparent)
  );

  function automatic logic [11:0] pal_rgb(input logic [3:0] i);
    if (i == 4'h0) return 12'hAEA;
    if (i == 4'h2) return 12'hFFF;
    return {i, ~i, i ^ 4'h5};
  endfunction

  always_comb {pal_red, pal_green, pal_blue} = pal_rgb(pal_index);

  function automatic logic [3:0] rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (last + k) % 4;
      if (v[idx]) return 4'b0001 << idx;
    end
    return 4'b0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at negedge, check outputs, then advance model at posedge.
  task automatic cycle(input logic rst, input logic [3:0] v, input logic [15:0] idx, input logic rr);
    logic [3:0] exp_g;
    logic adv1, adv2;
    int gid;
    @(negedge Clk);
    Reset = rst; req_valid = v; req_index = idx; rsp_ready = rr;
    #1;
    adv2 = !m_rsp_valid || rr;
    adv1 = !m_s1_valid || adv2;
    exp_g = (rst || !adv1) ? 4'b0000 : rr_pick(v, m_last);
    obs_ready = req_ready;
    obs_rsp = {rsp_id, rsp_red, rsp_green, rsp_blue, rsp_transparent};
    check_eq("req_ready", {28'd0, req_ready}, {28'd0, exp_g});
    check_eq("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rsp_valid});
    if (!rst && rsp_valid && rr) begin
      if (sb_q.size() == 0) check_eq("sb_empty", 32'd1, 32'd0);
      else check_eq("rsp_data", {17'd0, obs_rsp}, {17'd0, sb_q.pop_front()});
    end
    @(posedge Clk);
    if (rst) begin
      m_s1_valid = 1'b0; m_rsp_valid = 1'b0; m_last = 3; sb_q.delete();
    end else begin
      if (adv2) m_rsp_valid = m_s1_valid;
      if (adv1) m_s1_valid = (exp_g != 4'b0000);
      if (exp_g != 4'b0000) begin
        gid = 0;
        for (int i = 0; i < 4; i++) if (exp_g[i]) gid = i;
        m_last = gid;
        sb_q.push_back({2'(gid), pal_rgb(idx[gid*4 +: 4]), (idx[gid*4 +: 4] == 4'h0)});
      end
    end
  endtask

  task automatic check_reset_state();
    #1;
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_bus", {17'd0, rsp_id, rsp_red, rsp_green, rsp_blue, rsp_transparent}, 32'd0);
    check_eq("rst_pal_index", {28'd0, pal_index}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; req_valid = 4'b0000; req_index = 16'h0000; rsp_ready = 1'b1;
    m_s1_valid = 1'b0; m_rsp_valid = 1'b0; m_last = 3;

    // Reset with all requesters asserting: no grant during reset.
    cycle(1'b1, 4'b1111, 16'h3210, 1'b1);
    check_reset_state();

    // Single request, index 2 -> FFF, opaque, two cycles later.
    cycle(1'b0, 4'b0001, 16'h0002, 1'b1);
    check_eq("single_grant", {28'd0, obs_ready}, 32'h1);
    cycle(1'b0, 4'b0000, 16'h0000, 1'b1);
    cycle(1'b0, 4'b0000, 16'h0000, 1'b1);
    check_eq("single_rsp", {17'd0, obs_rsp}, {17'd0, 2'd0, 12'hFFF, 1'b0});

    // Requester 2 sends the transparent index.
    cycle(1'b0, 4'b0100, 16'h0000, 1'b1);
    cycle(1'b0, 4'b0000, 16'h0000, 1'b1);
    cycle(1'b0, 4'b0000, 16'h0000, 1'b1);
    check_eq("transp_rsp", {17'd0, obs_rsp}, {17'd0, 2'd2, 12'hAEA, 1'b1});

    // Fairness from reset: 0,1,2,3,0,1,2,3.
    cycle(1'b1, 4'b0000, 16'h0000, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 4'b1111, 16'h7531 + 16'(k * 16'h1111), 1'b1);
      check_eq("fair_order", {28'd0, obs_ready}, 32'h1 << (k % 4));
    end

    // Backpressure with pipeline full: no grants, response held stable.
    cycle(1'b0, 4'b1111, 16'hC9A4, 1'b0);
    held_rsp = obs_rsp;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 4'b1111, 16'h5BE3, 1'b0);
      check_eq("stall_ready", {28'd0, obs_ready}, 32'h0);
      check_eq("stall_hold", {17'd0, obs_rsp}, {17'd0, held_rsp});
    end
    // Release: drain in order and grant in the same cycle.
    cycle(1'b0, 4'b1111, 16'hD6F8, 1'b1);
    check_eq("release_grant", {31'd0, (obs_ready != 4'b0000)}, 32'd1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 4'b0000, 16'h0000, 1'b1);

    // Sparse round-robin: drive last_grant to 1, idle, then 0001 and 1001.
    cycle(1'b1, 4'b0000, 16'h0000, 1'b1);
    cycle(1'b0, 4'b0001, 16'h0004, 1'b1);
    cycle(1'b0, 4'b0010, 16'h0050, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'b0000, 16'h0000, 1'b1);
    cycle(1'b0, 4'b0001, 16'h0009, 1'b1);
    check_eq("sparse_g0", {28'd0, obs_ready}, 32'h1);
    cycle(1'b0, 4'b1001, 16'h600B, 1'b1);
    check_eq("sparse_g3", {28'd0, obs_ready}, 32'h8);
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'b0000, 16'h0000, 1'b1);
    check_eq("sb_drained", sb_q.size(), 32'd0);

    // Mid-stream reset with both stages valid.
    cycle(1'b0, 4'b1111, 16'h1234, 1'b1);
    cycle(1'b0, 4'b1111, 16'h5678, 1'b0);
    cycle(1'b1, 4'b1111, 16'h9ABC, 1'b1);
    check_reset_state();
    cycle(1'b0, 4'b1111, 16'hDEF1, 1'b1);
    check_eq("post_rst_first", {28'd0, obs_ready}, 32'h1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 4'b0000, 16'h0000, 1'b1);
    check_eq("sb_final", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/palette_lookup_arbiter.md
# palette_lookup_arbiter

Shares one combinational 16-entry sprite palette (4-bit index → 12-bit RGB) among several duck sprite pixel requesters. Each cycle it grants at most one pending request round-robin, drives the palette index, and registers the returned colour with the requester's ID and a transparency flag. The block sits between the per-duck sprite ROM readers and the frame-buffer writer. It has a two-stage pipeline with backpressure from the writer.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester ID, equal to clog2(NUM_REQ)
- TRANSPARENT_IDX, 4'h0, palette index treated as background/transparent

Ports (clock and reset first):
- Clk  in  1  system clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high; one clock, active-high synchronous reset
- req_valid  in  NUM_REQ  requester i has a pixel index pending
- req_index  in  4*NUM_REQ  index for requester i, held in bits [4i+3:4i]
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i]
- pal_index  out  4  index presented to the external palette
- pal_red, pal_green, pal_blue  in  4 each  combinational palette response to pal_index
- rsp_valid  out  1  response stage holds valid data
- rsp_ready  in  1  downstream accepts the response
- rsp_id  out  ID_W  requester that issued the response
- rsp_red, rsp_green, rsp_blue  out  4 each  looked-up colour
- rsp_transparent  out  1  the index equalled TRANSPARENT_IDX

## Operation
- Stage S1 (lookup) registers: s1_valid, s1_id, s1_index. pal_index = s1_index.
- Stage S2 (response) registers: rsp_valid, rsp_id, the three rsp colour outputs, and rsp_transparent. These capture the pal_* inputs and (s1_index == TRANSPARENT_IDX).
- Stall rules:
  - advance2 = !rsp_valid || rsp_ready.
  - advance1 = !s1_valid || advance2.
- Grant rules:
  - req_ready is asserted combinationally only when advance1 = 1.
  - req_ready is one-hot, or zero when no request is valid or the pipeline is stalled.
- Round-robin:
  - Pointer last_grant (ID_W bits) records the most recent grant.
  - Search order is last_grant+1, last_grant+2, …, wrapping modulo NUM_REQ.
  - The first requester with req_valid = 1 wins.
  - last_grant updates only on an actual transfer.
- On a transfer, S1 loads the grant's ID and index with s1_valid = 1. If advance1 = 1 with no transfer, s1_valid is set to 0.
- When advance2 = 1, S2 loads from S1, including s1_valid into rsp_valid.
- When stalled, both stages hold their contents unchanged. No response is dropped or duplicated.
- Simultaneous events:
  - If rsp_ready = 1 on the same cycle that S2 is full, S2 may both drain and reload.
  - A new grant is still issued in that cycle, giving full throughput of 1 pixel/cycle.
- A requester that drops req_valid before being granted is simply skipped. No state is kept per requester.
- Reset:
  - s1_valid = 0, rsp_valid = 0, s1_id = 0, s1_index = 0.
  - rsp_id, rsp colours and rsp_transparent are all 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
  - req_ready = 0 during the reset cycle.
  - Reset asserted mid-operation discards in-flight pixels with no response emitted.

## Timing
- Latency: a transfer in cycle N produces rsp_valid = 1 at cycle N+2, provided there is no stall.
- Throughput: one grant per cycle while rsp_ready = 1.
- req_ready has a combinational path from req_valid and rsp_ready. There is no combinational path from req_* to rsp_*.
- pal_index is registered. The palette response must settle within one cycle.
- Stall recovery: rsp_ready rising in cycle M allows a new grant in cycle M.
- Pipeline full condition: rsp_valid && s1_valid && !rsp_ready → req_ready = 0.
- Empty pipeline: pal_index holds its last value. The palette output is ignored.

## Test plan
- Reset then a single request: req_valid = 4'b0001, index 4'h2 at cycle 1 → req_ready[0] = 1 at cycle 1. At cycle 3: rsp_valid = 1, rsp_id = 0, RGB = F,F,F, rsp_transparent = 0.
- Transparency: requester 2 sends index 0 → rsp colour A,E,A with rsp_transparent = 1 and rsp_id = 2.
- Fairness: all four requesters continuously valid for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3. Responses arrive in the same order, two cycles later.
- Backpressure:
  - With the pipeline full, hold rsp_ready = 0 for 5 cycles → req_ready = 0 throughout, and rsp_* stays stable.
  - Release rsp_ready → the held responses drain in order with none lost, then grants resume in the same cycle.
- Sparse round-robin: last_grant = 1, req_valid = 4'b0001 then 4'b1001 → grants go to 0 then 3. last_grant is unchanged on idle cycles.
- Mid-stream reset: Reset asserted with both stages valid → the next cycle shows rsp_valid = 0 and req_ready = 0. After release, requester 0 is granted first.
